// File: rtl/bip_pkg.sv
// -----------------------------------------------------------------------------
// bip_pkg
//   Shared constants for the accumulator CPU control unit: field widths,
//   opcode values, datapath select/ALU encodings and FSM state encoding.
//   No ports; imported by program_counter and bip_control_unit.
// -----------------------------------------------------------------------------
package bip_pkg;

  // Default field widths.
  localparam int unsigned PC_W    = 11;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned CNT_W   = 32;

  // Opcodes (instr[15:11]). Anything from 5'b01000 upward executes as NOP.
  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  // Accumulator source select.
  localparam logic [1:0] SEL_IN  = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  // ALU operation.
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // FSM state encoding.
  localparam logic [1:0] ST_FETCH  = 2'b00;
  localparam logic [1:0] ST_DECODE = 2'b01;
  localparam logic [1:0] ST_MEM    = 2'b10;
  localparam logic [1:0] ST_HALT   = 2'b11;

  // Instructions that need a data-RAM read and therefore a MEM cycle.
  function automatic logic is_mem_op(input logic [4:0] opc);
    return (opc == OPC_LD) || (opc == OPC_ADD) || (opc == OPC_SUB);
  endfunction

endpackage

// File: rtl/bip_control_unit_program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//   Program counter register. Increments by one when inc is high and wraps
//   modulo 2**WIDTH.
// Ports
//   clk    in  1      system clock
//   rst_n  in  1      asynchronous active-low reset (pc -> 0)
//   inc    in  1      advance pc this cycle
//   pc     out WIDTH  current program address
// -----------------------------------------------------------------------------
module program_counter
  import bip_pkg::*;
#(
  parameter int unsigned WIDTH = PC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Natural overflow of the adder provides the wrap to zero.
  always_comb begin
    pc_d = inc ? pc_q + WIDTH'(1) : pc_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/bip_control_unit.sv
// -----------------------------------------------------------------------------
// bip_control_unit
//   Control side of the accumulator CPU. Fetches instructions from a
//   synchronous program ROM, decodes them, drives datapath strobes and the
//   data-RAM read/write requests, detects HLT and counts executed cycles.
// Ports
//   clk        in   1            system clock
//   rst_n      in   1            asynchronous active-low reset
//   enable     in   1            1 = advance this cycle, 0 = full stall
//   prog_addr  out  PC_WIDTH     program ROM address (= pc)
//   instr      in   INSTR_WIDTH  ROM data, valid the cycle after prog_addr
//   operand    out  11           datapath operand / RAM address
//   sel_a      out  2            accumulator source (in_data/imm/alu)
//   sel_b      out  1            ALU B source: 1 operand, 0 in_data
//   op         out  1            ALU op: 0 add, 1 sub
//   wr_acc     out  1            accumulator write strobe
//   rd_ram     out  1            data RAM read request
//   wr_ram     out  1            data RAM write strobe
//   halted     out  1            high while in HALT
//   cycle_cnt  out  CNT_WIDTH    enabled, non-halted cycles since reset
// -----------------------------------------------------------------------------
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = PC_W,
  parameter int unsigned INSTR_WIDTH = INSTR_W,
  parameter int unsigned OPC_WIDTH   = OPC_W,
  parameter int unsigned CNT_WIDTH   = CNT_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  output logic [PC_WIDTH-1:0]                prog_addr,
  input  logic [INSTR_WIDTH-1:0]             instr,
  output logic [INSTR_WIDTH-OPC_WIDTH-1:0]   operand,
  output logic [1:0]                         sel_a,
  output logic                               sel_b,
  output logic                               op,
  output logic                               wr_acc,
  output logic                               rd_ram,
  output logic                               wr_ram,
  output logic                               halted,
  output logic [CNT_WIDTH-1:0]               cycle_cnt
);

  localparam int unsigned OPND_WIDTH = INSTR_WIDTH - OPC_WIDTH;

  logic [1:0]             state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PC_WIDTH-1:0]    pc;
  logic                   pc_inc;

  logic                   wr_acc_raw, wr_ram_raw, rd_ram_raw;
  logic [OPC_WIDTH-1:0]   instr_opc, ir_opc;

  assign instr_opc = instr[INSTR_WIDTH-1 -: OPC_WIDTH];
  assign ir_opc    = ir_q[INSTR_WIDTH-1 -: OPC_WIDTH];

  program_counter #(
    .WIDTH (PC_WIDTH)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_inc),
    .pc    (pc)
  );

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_inc     = 1'b0;
    operand    = ir_q[OPND_WIDTH-1:0];
    sel_a      = SEL_IN;
    sel_b      = 1'b0;
    op         = ALU_ADD;
    wr_acc_raw = 1'b0;
    wr_ram_raw = 1'b0;
    rd_ram_raw = 1'b0;
    halted     = 1'b0;

    case (state_q)
      ST_FETCH: state_d = ST_DECODE;

      ST_DECODE: begin
        ir_d    = instr;
        operand = instr[OPND_WIDTH-1:0];
        if (instr_opc == OPC_HLT) begin
          state_d = ST_HALT;
        end else if (is_mem_op(instr_opc)) begin
          rd_ram_raw = 1'b1;
          state_d    = ST_MEM;
        end else begin
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
          case (instr_opc)
            OPC_LDI: begin
              wr_acc_raw = 1'b1;
              sel_a      = SEL_IMM;
            end
            OPC_ADDI, OPC_SUBI: begin
              wr_acc_raw = 1'b1;
              sel_a      = SEL_ALU;
              sel_b      = 1'b1;
              op         = (instr_opc == OPC_SUBI) ? ALU_SUB : ALU_ADD;
            end
            OPC_STO: wr_ram_raw = 1'b1;
            default: ;  // NOP
          endcase
        end
      end

      ST_MEM: begin
        // RAM data for the operand address is on in_data now.
        wr_acc_raw = 1'b1;
        pc_inc     = 1'b1;
        state_d    = ST_FETCH;
        if (ir_opc != OPC_LD) begin
          sel_a = SEL_ALU;
          op    = (ir_opc == OPC_SUB) ? ALU_SUB : ALU_ADD;
        end
      end

      default: halted = 1'b1;  // ST_HALT: absorbing
    endcase

    // A stalled cycle changes nothing.
    if (!enable) begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_inc  = 1'b0;
    end

    cnt_d = (enable && state_q != ST_HALT) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write strobes only fire on cycles that advance. The read request is kept
  // up through a MEM stall so in_data keeps presenting the operand's data.
  assign wr_acc    = wr_acc_raw & enable;
  assign wr_ram    = wr_ram_raw & enable;
  assign rd_ram    = enable ? rd_ram_raw : (state_q == ST_MEM);
  assign prog_addr = pc;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// -----------------------------------------------------------------------------
// tb_bip_control_unit
//   Directed programs run from a ROM model. Expected strobe events are queued
//   before each program; a monitor pops one whenever the DUT raises wr_acc,
//   wr_ram or rd_ram and compares cycle, selects, operand and pc.
// -----------------------------------------------------------------------------
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] prog_addr, operand;
  logic [15:0] instr;
  logic [1:0]  sel_a;
  logic        sel_b, op, wr_acc, rd_ram, wr_ram, halted;
  logic [31:0] cycle_cnt;

  logic [15:0] rom [0:2047];

  int tick    = 0;
  int base    = 0;
  int n_tests = 0;
  int n_fail  = 0;

  // Packed event layout: cyc[44:29] wr_acc[28] wr_ram[27] rd_ram[26]
  // sel_a[25:24] sel_b[23] op[22] operand[21:11] pc[10:0]
  localparam logic [63:0] DC_NONE = 64'd0;
  localparam logic [63:0] DC_RD   = 64'h1 << 26;
  localparam logic [63:0] DC_SEL  = 64'hF << 22;

  typedef struct {
    int          cyc;
    logic        wr_acc, wr_ram, rd_ram;
    logic [1:0]  sel_a;
    logic        sel_b, op;
    logic [10:0] operand, pc;
    logic [63:0] dc;
  } exp_t;

  exp_t exp_q[$];

  bip_control_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .prog_addr (prog_addr),
    .instr     (instr),
    .operand   (operand),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .op        (op),
    .wr_acc    (wr_acc),
    .rd_ram    (rd_ram),
    .wr_ram    (wr_ram),
    .halted    (halted),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle read latency.
  always @(posedge clk) begin
    tick  <= tick + 1;
    instr <= rom[prog_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int cyc, input logic wa, input logic wr, input logic rd,
                         input logic [1:0] sa, input logic sb, input logic o,
                         input logic [10:0] opnd, input logic [10:0] pc,
                         input logic [63:0] dc);
    exp_t e;
    e.cyc = cyc; e.wr_acc = wa; e.wr_ram = wr; e.rd_ram = rd;
    e.sel_a = sa; e.sel_b = sb; e.op = o; e.operand = opnd; e.pc = pc; e.dc = dc;
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, mid-cycle.
  initial begin
    exp_t        e;
    logic [63:0] act, expv;
    forever begin
      @(negedge clk);
      if (rst_n && (wr_acc || wr_ram || rd_ram)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'({wr_acc, wr_ram, rd_ram}), 64'd0);
        end else begin
          e    = exp_q.pop_front();
          act  = {19'd0, 16'(tick - base), wr_acc, wr_ram, rd_ram, sel_a, sel_b, op,
                  operand, prog_addr};
          expv = {19'd0, 16'(e.cyc), e.wr_acc, e.wr_ram, e.rd_ram, e.sel_a, e.sel_b, e.op,
                  e.operand, e.pc};
          check("strobe_event", act & ~e.dc, expv & ~e.dc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 16'h4000;  // NOP
  endtask

  // Holds reset for two cycles, releases it just after a rising edge; the
  // clock period in progress is then cycle 1 (FETCH of pc 0).
  task automatic start_prog();
    enable = 1'b1;
    rst_n  = 1'b0;
    step(2);
    rst_n = 1'b1;
    base  = tick - 1;
  endtask

  initial begin
    // ---------------- reset values ----------------
    rst_n  = 1'b0;
    enable = 1'b1;
    clear_rom();
    step(2);
    check("rst_prog_addr", 64'(prog_addr), 64'd0);
    check("rst_strobes", 64'({wr_acc, wr_ram, rd_ram}), 64'd0);
    check("rst_sel_op", 64'({sel_a, sel_b, op}), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);

    // ---------------- LDI 5; ADDI 3; STO 7; HLT ----------------
    clear_rom();
    rom[0] = 16'h1805;
    rom[1] = 16'h2803;
    rom[2] = 16'h0807;
    rom[3] = 16'h0000;
    push_ev(2, 1, 0, 0, 2'b01, 0, 0, 11'd5, 11'd0, DC_NONE);
    push_ev(4, 1, 0, 0, 2'b10, 1, 0, 11'd3, 11'd1, DC_NONE);
    push_ev(6, 0, 1, 0, 2'b00, 0, 0, 11'd7, 11'd2, DC_NONE);
    start_prog();
    check("p1_c1_prog_addr", 64'(prog_addr), 64'd0);
    check("p1_c1_cycle_cnt", 64'(cycle_cnt), 64'd0);
    step(2);
    check("p1_c3_operand_holds_ir", 64'(operand), 64'd5);
    check("p1_c3_prog_addr", 64'(prog_addr), 64'd1);
    step(5);
    check("p1_c8_not_halted", 64'(halted), 64'd0);
    step(1);
    check("p1_c9_halted", 64'(halted), 64'd1);
    check("p1_c9_cycle_cnt", 64'(cycle_cnt), 64'd8);
    check("p1_c9_prog_addr", 64'(prog_addr), 64'd3);
    step(4);
    check("p1_c13_cnt_frozen", 64'(cycle_cnt), 64'd8);
    check("p1_c13_halted", 64'(halted), 64'd1);
    check("p1_drain", 64'(exp_q.size()), 64'd0);

    // ---------------- LD 2; SUB 3; HLT ----------------
    clear_rom();
    rom[0] = 16'h1002;
    rom[1] = 16'h3003;
    rom[2] = 16'h0000;
    push_ev(2, 0, 0, 1, 2'b00, 0, 0, 11'd2, 11'd0, DC_SEL);
    push_ev(3, 1, 0, 0, 2'b00, 0, 0, 11'd2, 11'd0, DC_RD);
    push_ev(5, 0, 0, 1, 2'b00, 0, 0, 11'd3, 11'd1, DC_SEL);
    push_ev(6, 1, 0, 0, 2'b10, 0, 1, 11'd3, 11'd1, DC_RD);
    start_prog();
    step(2);
    check("p2_c3_pc_held", 64'(prog_addr), 64'd0);
    step(1);
    check("p2_c4_pc", 64'(prog_addr), 64'd1);
    step(2);
    check("p2_c6_pc_held", 64'(prog_addr), 64'd1);
    step(1);
    check("p2_c7_pc", 64'(prog_addr), 64'd2);
    step(3);
    check("p2_c10_halted", 64'(halted), 64'd1);
    check("p2_c10_cycle_cnt", 64'(cycle_cnt), 64'd8);
    check("p2_drain", 64'(exp_q.size()), 64'd0);

    // ---------------- ADD 5 with a 3-cycle stall in MEM ----------------
    clear_rom();
    rom[0] = 16'h2005;
    rom[1] = 16'h0000;
    push_ev(2, 0, 0, 1, 2'b00, 0, 0, 11'd5, 11'd0, DC_SEL);
    push_ev(3, 0, 0, 1, 2'b10, 0, 0, 11'd5, 11'd0, DC_SEL);
    push_ev(4, 0, 0, 1, 2'b10, 0, 0, 11'd5, 11'd0, DC_SEL);
    push_ev(5, 0, 0, 1, 2'b10, 0, 0, 11'd5, 11'd0, DC_SEL);
    push_ev(6, 1, 0, 0, 2'b10, 0, 0, 11'd5, 11'd0, DC_RD);
    start_prog();
    step(2);
    enable = 1'b0;
    check("p3_c3_cycle_cnt", 64'(cycle_cnt), 64'd2);
    step(1);
    check("p3_c4_stall_rd_wr", 64'({rd_ram, wr_acc}), 64'b10);
    step(2);
    check("p3_c6_cnt_frozen", 64'(cycle_cnt), 64'd2);
    check("p3_c6_pc_frozen", 64'(prog_addr), 64'd0);
    enable = 1'b1;
    step(1);
    check("p3_c7_pc", 64'(prog_addr), 64'd1);
    check("p3_c7_cycle_cnt", 64'(cycle_cnt), 64'd3);
    step(3);
    check("p3_c10_halted", 64'(halted), 64'd1);
    check("p3_c10_cycle_cnt", 64'(cycle_cnt), 64'd5);
    check("p3_drain", 64'(exp_q.size()), 64'd0);

    // ---------------- reset during MEM of LD ----------------
    clear_rom();
    rom[1] = 16'h1004;
    push_ev(4, 0, 0, 1, 2'b00, 0, 0, 11'd4, 11'd1, DC_SEL);
    start_prog();
    step(4);
    check("p4_c5_prog_addr", 64'(prog_addr), 64'd1);
    check("p4_c5_cycle_cnt", 64'(cycle_cnt), 64'd4);
    rst_n = 1'b0;
    #2;
    check("p4_async_prog_addr", 64'(prog_addr), 64'd0);
    check("p4_async_cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("p4_async_strobes", 64'({wr_acc, wr_ram, rd_ram, halted}), 64'd0);
    check("p4_async_operand", 64'(operand), 64'd0);
    step(1);
    check("p4_drain", 64'(exp_q.size()), 64'd0);

    // ---------------- NOP run to pc 2047, opcode 11111, wrap ----------------
    clear_rom();
    rom[2047] = 16'hF955;
    start_prog();
    step(4094);
    check("p5_c4095_prog_addr", 64'(prog_addr), 64'd2047);
    step(1);
    check("p5_c4096_strobes", 64'({wr_acc, wr_ram, rd_ram}), 64'd0);
    check("p5_c4096_operand", 64'(operand), 64'h155);
    step(1);
    check("p5_c4097_wrap", 64'(prog_addr), 64'd0);
    check("p5_c4097_cycle_cnt", 64'(cycle_cnt), 64'd4096);
    check("p5_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
